// File: rtl/mips_fetch_stage.sv
// MIPS instruction fetch stage: PC register, word-addressed instruction memory
// and the IF/ID pipeline register, with redirect, stall and misalignment tracking.
module mips_fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          IMEM_DEPTH = 64,
  localparam int         AW         = $clog2(IMEM_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [31:0]   redirect_pc,
  input  logic          load_we,
  input  logic [AW-1:0] load_addr,
  input  logic [31:0]   load_data,
  output logic [31:0]   pc,
  output logic [31:0]   ifid_ins,
  output logic [31:0]   ifid_pc4,
  output logic          ifid_valid,
  output logic          misaligned
);

  logic [31:0]   r_mem [IMEM_DEPTH];
  logic [31:0]   r_pc;
  logic [31:0]   r_ifid_ins;
  logic [31:0]   r_ifid_pc4;
  logic          r_ifid_valid;
  logic          r_misaligned;

  logic [AW-1:0] w_fetch_idx;
  logic [31:0]   w_fetch_word;
  logic [31:0]   w_pc_plus4;
  logic [31:0]   w_redirect_aligned;
  logic          w_redirect_misaligned;

  // Upper PC bits are dropped, so fetch addresses alias modulo the memory size.
  assign w_fetch_idx           = r_pc[AW+1:2];
  assign w_fetch_word          = r_mem[w_fetch_idx];
  assign w_pc_plus4            = r_pc + 32'd4;
  assign w_redirect_aligned    = {redirect_pc[31:2], 2'b00};
  assign w_redirect_misaligned = redirect && (redirect_pc[1:0] != 2'b00);

  // Loads are blocked during reset; the array itself is never cleared.
  always_ff @(posedge clk) begin
    if (!rst && load_we) begin
      r_mem[load_addr] <= load_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ifid_ins   <= 32'h0;
      r_ifid_pc4   <= 32'h0;
      r_ifid_valid <= 1'b0;
      r_misaligned <= 1'b0;
    end else begin
      if (redirect) begin
        r_pc         <= w_redirect_aligned;
        r_ifid_ins   <= 32'h0;
        r_ifid_pc4   <= 32'h0;
        r_ifid_valid <= 1'b0;
      end else if (!stall) begin
        r_pc         <= w_pc_plus4;
        r_ifid_ins   <= w_fetch_word;
        r_ifid_pc4   <= w_pc_plus4;
        r_ifid_valid <= 1'b1;
      end
      if (w_redirect_misaligned) begin
        r_misaligned <= 1'b1;
      end
    end
  end

  assign pc         = r_pc;
  assign ifid_ins   = r_ifid_ins;
  assign ifid_pc4   = r_ifid_pc4;
  assign ifid_valid = r_ifid_valid;
  assign misaligned = r_misaligned;

endmodule
